matrix_result_reader: RTL and testbench
=======================================

MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

Interface
REQ-001 The block SHALL have these parameters:
- CNT, 64, number of result columns (RAM banks).
- BIT, $clog2(CNT), address width.
- RD_LAT, 2, result-RAM read latency in cycles (1..4).

REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all logic on the rising edge.
- rstn_in  input  1  synchronous, active-low reset.
- start_in  input  1  drain request; its rising edge is detected.
- mm_rdy_in  input  1  multiplier ready; high means the result RAM is complete.
- rows_in  input  BIT+1  number of result rows to read (0..CNT).
- shift_in  input  5  arithmetic right-shift applied before narrowing.
- addrb_out  output  BIT  result-RAM read address.
- doutb_in  input  CNT x 32  result-RAM read data, signed.
- m_valid_out  output  1  output beat valid.
- m_ready_in  input  1  downstream accepts the beat.
- m_data_out  output  CNT x 16  one result row, narrowed, signed.
- m_row_out  output  BIT  row index of the current beat.
- m_last_out  output  1  the current beat is the final row.
- busy_out  output  1  a drain is in progress.
- done_out  output  1  one-cycle pulse when a drain completes.

Function
REQ-003 The state machine SHALL have the states IDLE, WAIT_RDY, READ and DRAIN.
REQ-004 In IDLE, a start_in rising edge SHALL latch rows_in (clamped to CNT) and shift_in, and SHALL move the block to WAIT_RDY.
REQ-005 A start_in rising edge outside IDLE SHALL be ignored.
REQ-006 If the latched row count is 0, the block SHALL go directly to IDLE, pulse done_out and emit no beats.
REQ-007 WAIT_RDY SHALL hold until mm_rdy_in=1, then move to READ with the read address set to 0.
REQ-008 In READ, one address SHALL be issued per cycle while (in-flight reads + FIFO occupancy) < RD_LAT+2.
REQ-009 Each issued address SHALL increment by 1; after the last row (latched rows − 1) is issued, the block SHALL move to DRAIN.
REQ-010 Read data SHALL be captured exactly RD_LAT cycles after its address into a skid FIFO of depth RD_LAT+2, tagged with its row index.
REQ-011 Beats SHALL leave in row order, each row exactly once, with no loss or duplication under any m_ready_in pattern.
REQ-012 Valid/ready handshake rules:
- A beat SHALL transfer only on a cycle with m_valid_out=1 and m_ready_in=1.
- While m_valid_out=1 and m_ready_in=0, m_data_out, m_row_out and m_last_out SHALL be held stable.
REQ-013 m_valid_out SHALL NOT depend combinationally on m_ready_in.
REQ-014 m_last_out SHALL be 1 only on the beat whose m_row_out equals latched rows − 1.
REQ-015 DRAIN SHALL exit to IDLE on the cycle after the last beat transfers, with done_out=1 for exactly that one cycle.
REQ-016 busy_out SHALL be 1 in every state except IDLE.
REQ-017 Narrowing per element:
- Compute s = doutb >>> shift_in (sign-extending).
- The output is the 16-bit result of s per REQ-024.
REQ-018 With unbroken m_ready_in=1, throughput SHALL be one beat per cycle.
REQ-019 Latency SHALL be RD_LAT+1 cycles from the first address issue to the first m_valid_out.
REQ-020 addrb_out SHALL hold its last value when no read is issued.

Reset
REQ-021 While rstn_in=0 at a clock edge, the block SHALL apply these values:
- state = IDLE;
- FIFO emptied;
- in-flight tags cleared;
- addrb_out = 0, m_valid_out = 0, m_data_out = 0, m_row_out = 0, m_last_out = 0, busy_out = 0, done_out = 0;
- start edge detector cleared to 0.
REQ-022 Reset asserted mid-drain SHALL abort the drain without a done_out pulse.
REQ-023 Read data returning after reset SHALL be discarded.

Configuration
REQ-024 Macro MATRIX_RESULT_SAT_EN SHALL select the narrowing mode:
- Defined: s SHALL be clamped to [-32768, 32767].
- Undefined: the output SHALL be s[15:0] (wrap-around truncation).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- RD_LAT=2, rows_in=3, mm_rdy_in=1, m_ready_in=1, start pulse → beats for rows 0,1,2 on 3 consecutive cycles, m_last_out on row 2, done_out one cycle later, busy_out low afterwards.
- rows_in=0, start pulse → no m_valid_out and a done_out pulse.
- m_ready_in toggled 1,0,0,1,0,1..., rows_in=8 → 8 beats in order, data held stable during stalls, no duplicates.
- doutb=0x0001_0000 with shift_in=0 → MATRIX_RESULT_SAT_EN defined gives 0x7FFF; undefined gives 0x0000.
- doutb=0xFFFF_FF00 with shift_in=4 → 0xFFF0 in both modes.
- rstn_in=0 for one cycle after the 2nd beat of 8 → no further beats, no done_out pulse, state IDLE; a new start completes normally.

Source files
------------

// File: rtl/matrix_result_reader.sv
// Drains a banked result RAM row by row into a valid/ready stream of narrowed rows.
// Define MATRIX_RESULT_SAT_EN to saturate to 16 bits; otherwise the narrowing wraps.

module matrix_result_reader #(
   parameter int CNT    = 64,
   parameter int BIT    = $clog2(CNT),
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rstn_in,
   input  logic              start_in,
   input  logic              mm_rdy_in,
   input  logic [BIT:0]      rows_in,
   input  logic [4:0]        shift_in,
   output logic [BIT-1:0]    addrb_out,
   input  logic [CNT*32-1:0] doutb_in,
   output logic              m_valid_out,
   input  logic              m_ready_in,
   output logic [CNT*16-1:0] m_data_out,
   output logic [BIT-1:0]    m_row_out,
   output logic              m_last_out,
   output logic              busy_out,
   output logic              done_out
);

   localparam int DEPTH = RD_LAT + 2;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW    = $clog2(2 * DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WAIT_RDY, READ, DRAIN} state_t;
   state_t state, state_nxt;

   logic              start_q;
   logic              start_rise;
   logic [BIT:0]      rows_q;
   logic [BIT:0]      rows_clamped;
   logic [BIT:0]      issue_cnt;
   logic [4:0]        shift_q;
   logic              latch;
   logic              enter_read;
   logic              issue;
   logic              issue_last;
   logic              done_nxt;
   logic              pop;
   logic              capture;
   logic              credit_ok;

   logic              tag_v    [RD_LAT+1];
   logic [BIT-1:0]    tag_row  [RD_LAT+1];
   logic              tag_last [RD_LAT+1];

   logic [CNT*16-1:0] fifo_data [DEPTH];
   logic [BIT-1:0]    fifo_row  [DEPTH];
   logic              fifo_last [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [SW-1:0]     occ;
   logic [SW-1:0]     inflight;
   logic [SW-1:0]     credit_sum;
   logic [CNT*16-1:0] narrowed;

   function automatic logic [15:0] narrow(input logic signed [31:0] d, input logic [4:0] sh);
`ifdef MATRIX_RESULT_SAT_EN
      logic signed [31:0] s;
      s = d >>> sh;
      if (s > 32'sd32767)
         return 16'h7FFF;
      else if (s < -32'sd32768)
         return 16'h8000;
      else
         return s[15:0];
`else
      return 16'(d >>> sh);
`endif
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign start_rise   = start_in & ~start_q;
   assign rows_clamped = (rows_in > (BIT+1)'(CNT)) ? (BIT+1)'(CNT) : rows_in;
   assign issue_last   = (issue_cnt == rows_q - (BIT+1)'(1));
   assign m_valid_out  = (occ != '0);
   assign pop          = m_valid_out & m_ready_in;
   assign capture      = tag_v[RD_LAT];
   assign m_data_out   = fifo_data[rd_ptr];
   assign m_row_out    = fifo_row[rd_ptr];
   assign m_last_out   = fifo_last[rd_ptr];
   assign busy_out     = (state != IDLE);

   always_comb begin
      inflight = '0;
      for (int unsigned k = 0; k < RD_LAT + 1; k++)
         inflight = inflight + SW'(tag_v[k]);
   end

   // The beat leaving this cycle frees its slot, so back-to-back issue survives ready=1.
   assign credit_sum = inflight + occ - SW'(pop);
   assign credit_ok  = (credit_sum < SW'(DEPTH));

   always_comb begin
      narrowed = '0;
      for (int unsigned i = 0; i < CNT; i++)
         narrowed[i*16 +: 16] = narrow(doutb_in[i*32 +: 32], shift_q);
   end

   always_comb begin
      state_nxt  = state;
      latch      = 1'b0;
      enter_read = 1'b0;
      issue      = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start_rise) begin
               latch     = 1'b1;
               state_nxt = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (rows_q == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (mm_rdy_in) begin
               enter_read = 1'b1;
               state_nxt  = READ;
            end
         end
         READ: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (issue_last)
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last_out) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn_in)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rstn_in) begin
         start_q   <= 1'b0;
         done_out  <= 1'b0;
         rows_q    <= '0;
         shift_q   <= '0;
         issue_cnt <= '0;
         addrb_out <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         for (int unsigned k = 0; k < RD_LAT + 1; k++) begin
            tag_v[k]    <= 1'b0;
            tag_row[k]  <= '0;
            tag_last[k] <= 1'b0;
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_row[i]  <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         start_q  <= start_in;
         done_out <= done_nxt;

         if (latch) begin
            rows_q    <= rows_clamped;
            shift_q   <= shift_in;
            issue_cnt <= '0;
         end
         if (enter_read) begin
            addrb_out <= '0;
            issue_cnt <= '0;
         end
         if (issue) begin
            addrb_out <= issue_cnt[BIT-1:0];
            issue_cnt <= issue_cnt + (BIT+1)'(1);
         end

         tag_v[0]    <= issue;
         tag_row[0]  <= issue_cnt[BIT-1:0];
         tag_last[0] <= issue_last;
         for (int unsigned k = 1; k < RD_LAT + 1; k++) begin
            tag_v[k]    <= tag_v[k-1];
            tag_row[k]  <= tag_row[k-1];
            tag_last[k] <= tag_last[k-1];
         end

         if (capture) begin
            fifo_data[wr_ptr] <= narrowed;
            fifo_row[wr_ptr]  <= tag_row[RD_LAT];
            fifo_last[wr_ptr] <= tag_last[RD_LAT];
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + SW'(capture) - SW'(pop);
      end
   end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed and randomized drains checked against an arithmetic model of the row narrowing.
// Build with MATRIX_RESULT_SAT_EN defined to check the saturating variant.

module tb_matrix_result_reader;

   localparam int CNT    = 64;
   localparam int BIT    = $clog2(CNT);
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rstn_in;
   logic              start_in;
   logic              mm_rdy_in;
   logic [BIT:0]      rows_in;
   logic [4:0]        shift_in;
   logic [BIT-1:0]    addrb_out;
   logic [CNT*32-1:0] doutb_in;
   logic              m_valid_out;
   logic              m_ready_in;
   logic [CNT*16-1:0] m_data_out;
   logic [BIT-1:0]    m_row_out;
   logic              m_last_out;
   logic              busy_out;
   logic              done_out;

   matrix_result_reader #(.CNT(CNT), .BIT(BIT), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rstn_in    (rstn_in),
      .start_in   (start_in),
      .mm_rdy_in  (mm_rdy_in),
      .rows_in    (rows_in),
      .shift_in   (shift_in),
      .addrb_out  (addrb_out),
      .doutb_in   (doutb_in),
      .m_valid_out(m_valid_out),
      .m_ready_in (m_ready_in),
      .m_data_out (m_data_out),
      .m_row_out  (m_row_out),
      .m_last_out (m_last_out),
      .busy_out   (busy_out),
      .done_out   (done_out)
   );

   always #5 clk = ~clk;

   // Result RAM: data for the address of cycle c appears on doutb in cycle c+RD_LAT.
   logic [CNT*32-1:0] ram    [CNT];
   logic [BIT-1:0]    addr_d [RD_LAT];

   always @(posedge clk) begin
      for (int k = RD_LAT - 1; k > 0; k--)
         addr_d[k] <= addr_d[k-1];
      addr_d[0] <= addrb_out;
   end
   assign doutb_in = ram[addr_d[RD_LAT-1]];

   int                total = 0;
   int                bad   = 0;
   logic [CNT*16-1:0] last_beat;
   int                pat [6];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [CNT*16-1:0] obs, input logic [CNT*16-1:0] exp);
      int lane;
      lane = 0;
      for (int i = CNT - 1; i >= 0; i--)
         if (obs[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s lane=%0d observed=%04h expected=%04h", tag, lane,
                obs[lane*16 +: 16], exp[lane*16 +: 16]);
      end
   endtask

   // Floor division by 2^sh, then wrap or clamp to 16 bits.
   function automatic logic [15:0] exp_lane(input logic [31:0] d, input int sh);
      longint v, p, q;
      v = longint'($signed(d));
      p = longint'(1) << sh;
      if (v >= 0)
         q = v / p;
      else
         q = -((-v + p - 1) / p);
`ifdef MATRIX_RESULT_SAT_EN
      if (q > 32767)
         q = 32767;
      else if (q < -32768)
         q = -32768;
`endif
      return q[15:0];
   endfunction

   function automatic logic [CNT*16-1:0] exp_row(input int r, input int sh);
      logic [CNT*16-1:0] row;
      logic [CNT*32-1:0] src;
      src = ram[r];
      for (int l = 0; l < CNT; l++)
         row[l*16 +: 16] = exp_lane(src[l*32 +: 32], sh);
      return row;
   endfunction

   task automatic fill_random();
      for (int r = 0; r < CNT; r++)
         for (int l = 0; l < CNT; l++)
            case ($urandom_range(0, 5))
               0:       ram[r][l*32 +: 32] = 32'h7FFF_FFFF;
               1:       ram[r][l*32 +: 32] = 32'h8000_0000;
               2:       ram[r][l*32 +: 32] = 32'($urandom_range(0, 65535));
               default: ram[r][l*32 +: 32] = $urandom;
            endcase
   endtask

   task automatic fill_const(input logic [31:0] val);
      for (int l = 0; l < CNT; l++)
         ram[0][l*32 +: 32] = val;
   endtask

   // rmode: 0 ready always, 1 fixed 1,0,0,1,0,1 pattern, 2 random ready.
   task automatic run_drain(input int rows_req, input int sh, input int rmode,
                            input int rdy_delay, input int abort_after, input bit chaos);
      logic [CNT*16-1:0] expq [$];
      logic [CNT*16-1:0] exp_d;
      logic [CNT*16-1:0] held_data;
      logic [BIT-1:0]    held_row;
      logic              held_last;
      int                rows_eff, sent;
      bit                first_seen, prev_stall, expect_done, last_pending, finished, rdy;

      rows_eff = (rows_req > CNT) ? CNT : rows_req;
      for (int r = 0; r < rows_eff; r++)
         expq.push_back(exp_row(r, sh));

      @(negedge clk);
      rows_in    = (BIT+1)'(rows_req);
      shift_in   = 5'(sh);
      mm_rdy_in  = (rdy_delay == 0);
      m_ready_in = 1'b0;
      start_in   = 1'b1;

      if (rows_eff == 0) begin
         finished = 0;
         for (int k = 0; k < 20 && !finished; k++) begin
            @(negedge clk);
            start_in   = 1'b0;
            m_ready_in = 1'b1;
            chk("zero_valid", m_valid_out, 0);
            if (done_out) begin
               chk("zero_busy", busy_out, 0);
               finished = 1;
            end
         end
         chk("zero_done_seen", finished, 1);
         @(negedge clk);
         chk("zero_done_once", done_out, 0);
         return;
      end

      sent = 0; first_seen = 0; prev_stall = 0; expect_done = 0; last_pending = 0; finished = 0;
      held_data = '0; held_row = '0; held_last = 1'b0;
      for (int k = 0; k < 3000 && !finished; k++) begin
         @(negedge clk);
         if (k == 0)
            start_in = 1'b0;
         if (rdy_delay > 0 && k == rdy_delay)
            mm_rdy_in = 1'b1;

         if (expect_done) begin
            chk("done_pulse", done_out, 1);
            chk("idle_busy", busy_out, 0);
            chk("idle_valid", m_valid_out, 0);
            start_in   = 1'b0;
            m_ready_in = 1'b0;
            @(negedge clk);
            chk("done_once", done_out, 0);
            chk("busy_after", busy_out, 0);
            finished = 1;
         end else begin
            chk("done_early", done_out, 0);
            chk("busy_run", busy_out, 1);
            if (prev_stall) begin
               chk("stall_valid", m_valid_out, 1);
               chk_data("stall_data", m_data_out, held_data);
               chk("stall_row", m_row_out, held_row);
               chk("stall_last", m_last_out, held_last);
            end
            // start edge -> WAIT_RDY -> READ -> first issue, then RD_LAT+1 to valid
            if (!first_seen && m_valid_out) begin
               first_seen = 1;
               chk("latency", k, RD_LAT + 3 + rdy_delay);
            end
            if (rmode == 0 && first_seen && !last_pending)
               chk("throughput", m_valid_out, 1);

            if (abort_after >= 0 && sent == abort_after) begin
               rstn_in    = 1'b0;
               m_ready_in = 1'b1;
               start_in   = 1'b0;
               @(negedge clk);
               rstn_in = 1'b1;
               chk("abort_addr", addrb_out, 0);
               chk("abort_row", m_row_out, 0);
               for (int j = 0; j < 25; j++) begin
                  chk("abort_valid", m_valid_out, 0);
                  chk("abort_done", done_out, 0);
                  chk("abort_busy", busy_out, 0);
                  @(negedge clk);
               end
               return;
            end

            case (rmode)
               0:       rdy = 1;
               1:       rdy = (pat[k % 6] != 0);
               default: rdy = ($urandom_range(0, 9) < 7);
            endcase
            m_ready_in = rdy;

            if (m_valid_out && rdy) begin
               if (expq.size() == 0) begin
                  chk("extra_beat", 1, 0);
               end else begin
                  exp_d = expq.pop_front();
                  chk("row", m_row_out, sent);
                  chk_data("data", m_data_out, exp_d);
                  chk("last", m_last_out, (sent == rows_eff - 1));
                  last_beat = exp_d;
                  last_beat = m_data_out;
                  sent++;
                  if (sent == rows_eff) begin
                     expect_done  = 1;
                     last_pending = 1;
                  end
               end
            end
            prev_stall = m_valid_out && !rdy;
            held_data  = m_data_out;
            held_row   = m_row_out;
            held_last  = m_last_out;
            start_in   = (chaos && !last_pending) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      chk("drain_finished", finished, 1);
      chk("beat_count", sent, rows_eff);
   endtask

   initial begin
      pat = '{1, 0, 0, 1, 0, 1};
      rstn_in    = 1'b0;
      start_in   = 1'b0;
      mm_rdy_in  = 1'b0;
      rows_in    = '0;
      shift_in   = '0;
      m_ready_in = 1'b0;
      for (int r = 0; r < CNT; r++)
         ram[r] = '0;

      repeat (3) @(negedge clk);
      chk("rst_addr", addrb_out, 0);
      chk("rst_valid", m_valid_out, 0);
      chk_data("rst_data", m_data_out, '0);
      chk("rst_row", m_row_out, 0);
      chk("rst_last", m_last_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      rstn_in = 1'b1;
      @(negedge clk);

      fill_random();
      run_drain(3, 0, 0, 0, -1, 0);
      run_drain(0, 0, 0, 0, -1, 0);
      fill_random();
      run_drain(8, 3, 1, 0, -1, 0);

      fill_const(32'h0001_0000);
      run_drain(1, 0, 0, 0, -1, 0);
`ifdef MATRIX_RESULT_SAT_EN
      chk("sat_pos_lane0", last_beat[15:0], 16'h7FFF);
`else
      chk("wrap_pos_lane0", last_beat[15:0], 16'h0000);
`endif
      fill_const(32'hFFFF_FF00);
      run_drain(1, 4, 0, 0, -1, 0);
      chk("neg_shift_lane0", last_beat[15:0], 16'hFFF0);

      fill_random();
      run_drain(8, 2, 0, 0, 2, 0);
      run_drain(8, 2, 1, 0, -1, 0);

      fill_random();
      run_drain(64, 31, 0, 0, -1, 0);
      run_drain(100, 5, 2, 2, -1, 1);
      for (int i = 0; i < 4; i++) begin
         fill_random();
         run_drain(int'($urandom_range(1, CNT)), int'($urandom_range(0, 31)), 2,
                   int'($urandom_range(0, 3)), -1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
